// File: rtl/clint_trap.sv
// clint_trap: machine-mode trap/interrupt sequencer.
// Detects ecall/ebreak/mret and enabled interrupts in the execute stage.
// Updates mepc/mstatus/mcause through a one-write-per-cycle CSR port.
// Then issues a one-cycle PC redirect while holding the pipeline.
module clint_trap #(
   parameter logic [31:0] TIMER_CAUSE = 32'h80000007,
   parameter logic [31:0] EXT_CAUSE   = 32'h8000000B
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  int_flag_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        global_int_en_i,
   input  logic [31:0] csr_mtvec_i,
   input  logic [31:0] csr_mepc_i,
   input  logic [31:0] csr_mstatus_i,
   output logic        we_o,
   output logic [31:0] waddr_o,
   output logic [31:0] data_o,
   output logic        hold_flag_o,
   output logic        int_assert_o,
   output logic [31:0] int_addr_o
);

   typedef enum logic [2:0] {
      IDLE,
      W_MEPC,
      W_MSTATUS,
      W_MCAUSE,
      W_MRET,
      ASSERT
   } state_e;

   localparam logic [31:0] INST_ECALL  = 32'h00000073;
   localparam logic [31:0] INST_EBREAK = 32'h00100073;
   localparam logic [31:0] INST_MRET   = 32'h30200073;

   state_e      state_q, state_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] savedPc_q, savedPc_d;
   logic        fromMret_q, fromMret_d;

   logic isEcall, isEbreak, isMret, isIrq, inIdle, anyEvent;

   // Event decode; events only count while idle and out of reset.
   always_comb begin
      inIdle   = (state_q == IDLE) && !rst;
      isEcall  = inIdle && (inst_i == INST_ECALL);
      isEbreak = inIdle && (inst_i == INST_EBREAK);
      isMret   = inIdle && (inst_i == INST_MRET);
      isIrq    = inIdle && (int_flag_i != 8'h00) && global_int_en_i;
      anyEvent = isEcall || isEbreak || isMret || isIrq;
   end

   // Next state and latched trap context; sync events beat mret, mret beats irq.
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      savedPc_d  = savedPc_q;
      fromMret_d = fromMret_q;
      case (state_q)
         IDLE: begin
            if (isEcall || isEbreak) begin
               cause_d    = isEcall ? 32'd11 : 32'd3;
               savedPc_d  = inst_addr_i;
               fromMret_d = 1'b0;
               state_d    = W_MEPC;
            end else if (isMret) begin
               fromMret_d = 1'b1;
               state_d    = W_MRET;
            end else if (isIrq) begin
               cause_d    = int_flag_i[0] ? TIMER_CAUSE : EXT_CAUSE;
               savedPc_d  = jump_flag_i ? jump_addr_i : inst_addr_i;
               fromMret_d = 1'b0;
               state_d    = W_MEPC;
            end
         end
         W_MEPC:    state_d = W_MSTATUS;
         W_MSTATUS: state_d = W_MCAUSE;
         W_MCAUSE:  state_d = ASSERT;
         W_MRET:    state_d = ASSERT;
         ASSERT:    state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // State and context registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cause_q    <= 32'h0;
         savedPc_q  <= 32'h0;
         fromMret_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         savedPc_q  <= savedPc_d;
         fromMret_q <= fromMret_d;
      end
   end

   // CSR write port, stall and redirect decoded from state; all quiet in reset.
   always_comb begin
      we_o         = 1'b0;
      waddr_o      = 32'h0;
      data_o       = 32'h0;
      int_assert_o = 1'b0;
      int_addr_o   = 32'h0;
      hold_flag_o  = !rst && ((state_q != IDLE) || anyEvent);
      if (!rst) begin
         case (state_q)
            W_MEPC: begin
               we_o    = 1'b1;
               waddr_o = 32'h00000341;
               data_o  = savedPc_q;
            end
            W_MSTATUS: begin
               we_o    = 1'b1;
               waddr_o = 32'h00000300;
               data_o  = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                          1'b0, csr_mstatus_i[2:0]};
            end
            W_MCAUSE: begin
               we_o    = 1'b1;
               waddr_o = 32'h00000342;
               data_o  = cause_q;
            end
            W_MRET: begin
               we_o    = 1'b1;
               waddr_o = 32'h00000300;
               data_o  = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                          csr_mstatus_i[7], csr_mstatus_i[2:0]};
            end
            ASSERT: begin
               int_assert_o = 1'b1;
               int_addr_o   = fromMret_q ? csr_mepc_i : csr_mtvec_i;
            end
            default: begin
               we_o = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/clint_trap.md
CLINT_TRAP -- requirements
Module: clint_trap

Interface
REQ-001 SHALL have parameters: TIMER_CAUSE, 32'h80000007, mcause for timer interrupt; EXT_CAUSE, 32'h8000000B, mcause for any other interrupt.
REQ-002 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-003 Ports (name direction width meaning):
- clk  in  1  clock
- rst  in  1  sync active-high reset
- int_flag_i  in  8  interrupt request levels; bit0 = timer
- inst_i  in  32  instruction in execute stage
- inst_addr_i  in  32  address of inst_i
- jump_flag_i  in  1  execute stage is redirecting PC this cycle
- jump_addr_i  in  32  redirect target
- global_int_en_i  in  1  mstatus.MIE from CSR file
- csr_mtvec_i  in  32  current mtvec
- csr_mepc_i  in  32  current mepc
- csr_mstatus_i  in  32  current mstatus
- we_o  out  1  CSR write strobe
- waddr_o  out  32  CSR write address, {20'h0, csr number}
- data_o  out  32  CSR write data
- hold_flag_o  out  1  pipeline stall request
- int_assert_o  out  1  one-cycle PC redirect pulse
- int_addr_o  out  32  redirect target, valid while int_assert_o = 1

Function
REQ-004 Event decode, combinational, in IDLE only:
- ecall = inst_i == 32'h00000073
- ebreak = inst_i == 32'h00100073
- mret = inst_i == 32'h30200073
- irq = (int_flag_i != 0) && global_int_en_i
REQ-005 Priority SHALL be ecall/ebreak > mret > irq; exactly one event is accepted per cycle.
REQ-006 FSM states SHALL be IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, ASSERT.
REQ-007 On accepting a trap (sync or irq) in cycle N, the block SHALL latch cause and saved PC, then go to W_MEPC.
REQ-008 Latched cause SHALL be: ecall 32'd11; ebreak 32'd3; irq with int_flag_i[0]=1 TIMER_CAUSE, else EXT_CAUSE.
REQ-009 Saved PC SHALL be: sync inst_addr_i; irq jump_flag_i ? jump_addr_i : inst_addr_i.
REQ-010 Trap write sequence, one CSR write per cycle with we_o=1:
- N+1 W_MEPC: 12'h341 <= saved PC
- N+2 W_MSTATUS: 12'h300 <= {mstatus[31:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]}
- N+3 W_MCAUSE: 12'h342 <= cause
REQ-011 In W_MSTATUS, MPIE SHALL be set to the old MIE and MIE cleared.
REQ-012 On accepting mret in cycle N, the block SHALL go to W_MRET. N+1: 12'h300 <= {mstatus[31:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]}.
REQ-013 ASSERT (N+4 for a trap, N+2 for mret) SHALL drive int_assert_o=1 for exactly one cycle, then return to IDLE.
REQ-014 In ASSERT, int_addr_o SHALL be csr_mtvec_i for a trap and csr_mepc_i for mret, sampled in the ASSERT cycle.
REQ-015 hold_flag_o SHALL be 1 combinationally in the accept cycle and in every non-IDLE state, including ASSERT.
REQ-016 In IDLE with no event, and in ASSERT, we_o, waddr_o and data_o SHALL be 0. int_addr_o SHALL be 0 whenever int_assert_o=0.
REQ-017 Events arriving while not in IDLE SHALL be ignored, not queued. A still-asserted int_flag_i is re-evaluated on the first IDLE cycle, using the updated MIE.
REQ-018 An irq SHALL NOT be accepted in the same IDLE cycle as a sync event or mret.

Reset
REQ-019 While rst=1 the FSM SHALL enter IDLE, and all outputs and latched cause/PC SHALL be 0 on the next edge.
REQ-020 Reset mid-sequence SHALL abort with no further writes; CSR writes already issued are not undone.

Verification
REQ-021 ecall at inst_addr_i=32'h100, mstatus=32'h8, mtvec=32'h200 -> writes 341<=100, 300<=80, 342<=B in N+1..N+3; N+4 int_assert_o=1, int_addr_o=200; hold 1 for N..N+4.
REQ-022 int_flag_i=8'h01, MIE=1, jump_flag_i=1, jump_addr_i=32'h340 -> mepc<=340, mcause<=80000007; int_flag_i=8'h04 -> mcause<=8000000B.
REQ-023 mret, mstatus=32'h80, mepc=32'h104 -> N+1 300<=88; N+2 int_assert_o=1, int_addr_o=104.
REQ-024 int_flag_i=8'h01 with MIE=0 -> no writes, hold_flag_o=0. ebreak and int_flag_i=8'h01 in the same cycle -> mcause<=3. Irq held during sequence -> not re-taken after MIE cleared.
REQ-025 rst asserted in W_MSTATUS -> no mcause write, no int_assert_o; next cycle all outputs 0, FSM IDLE.
